// File: rtl/hazard_pkg.sv
// Shared types and RV32 decode constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [6:0] LOAD          = 7'b0000011;
    localparam logic [6:0] FLW           = 7'b0000111;
    localparam logic [6:0] OP            = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_load_op(input logic [6:0] opcode);
        return (opcode == LOAD) || (opcode == FLW);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode fields, stall sources and register controls.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       ex_opcode;
    logic [6:0]       ex_funct7;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_branch_taken;
    logic             im_stall;
    logic             dm_stall;
    logic             md_done;
    logic             cnt_clr;

    logic             md_start;
    logic             pc_hold;
    logic             if_id_hold;
    logic             id_ex_hold;
    logic             ex_mem_hold;
    logic             mem_wb_hold;
    logic             if_id_flush;
    logic             id_ex_nop;
    logic             ex_mem_nop;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_opcode, ex_funct7, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_branch_taken, im_stall, dm_stall, md_done, cnt_clr,
        input  md_start, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
               if_id_flush, id_ex_nop, ex_mem_nop, md_err, stall_cnt
    );

    modport slave (
        input  ex_opcode, ex_funct7, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_branch_taken, im_stall, dm_stall, md_done, cnt_clr,
        output md_start, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
               if_id_flush, id_ex_nop, ex_mem_nop, md_err, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign q = count_reg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Prioritised hold/bubble/flush scheduler for the 5-stage core: memory wait, MUL/DIV, branch, load-use.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam int                  MD_CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST  = MD_CNT_W'(MD_TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [MD_CNT_W-1:0] md_cnt_reg, md_cnt_next;
    logic                done_pend_reg, done_pend_next;
    logic                md_err_reg, md_err_next;

    logic is_load, is_md, mem_wait, load_use, md_ready, md_timeout;
    logic launch, hold_fetch, hold_idex, hold_back, flush, id_nop, ex_nop;

    assign is_load    = is_load_op(bus.ex_opcode);
    assign is_md      = (bus.ex_opcode == OP) && (bus.ex_funct7 == FUNCT7_MULDIV);
    assign mem_wait   = bus.im_stall | bus.dm_stall;
    assign load_use   = is_load && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign md_ready   = (bus.md_done || done_pend_reg) && !mem_wait;
    assign md_timeout = (md_cnt_reg == MD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            md_cnt_reg    <= '0;
            done_pend_reg <= 1'b0;
            md_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            md_cnt_reg    <= md_cnt_next;
            done_pend_reg <= done_pend_next;
            md_err_reg    <= md_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        md_cnt_next    = md_cnt_reg;
        done_pend_next = done_pend_reg;
        md_err_next    = md_err_reg;
        launch         = 1'b0;
        hold_fetch     = 1'b0;
        hold_idex      = 1'b0;
        hold_back      = 1'b0;
        flush          = 1'b0;
        id_nop         = 1'b0;
        ex_nop         = 1'b0;

        case (state_reg)
            RUN: begin
                if (mem_wait) begin
                    hold_fetch = 1'b1;
                    hold_idex  = 1'b1;
                    hold_back  = 1'b1;
                end else if (is_md && !md_err_reg) begin
                    // After a timeout the unit is not trusted again until reset.
                    launch         = 1'b1;
                    hold_fetch     = 1'b1;
                    hold_idex      = 1'b1;
                    ex_nop         = 1'b1;
                    state_next     = MD_WAIT;
                    md_cnt_next    = '0;
                    done_pend_next = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    flush  = 1'b1;
                    id_nop = 1'b1;
                end else if (load_use) begin
                    hold_fetch = 1'b1;
                    id_nop     = 1'b1;
                end
            end

            MD_WAIT: begin
                md_cnt_next = md_cnt_reg + MD_CNT_W'(1);
                if (md_ready) begin
                    state_next     = RUN;
                    done_pend_next = 1'b0;
                end else if (md_timeout) begin
                    // Forced exit drops the result; a concurrent memory wait still freezes.
                    state_next     = RUN;
                    done_pend_next = 1'b0;
                    md_err_next    = 1'b1;
                    ex_nop         = 1'b1;
                    hold_fetch     = mem_wait;
                    hold_idex      = mem_wait;
                    hold_back      = mem_wait;
                end else begin
                    hold_fetch = 1'b1;
                    hold_idex  = 1'b1;
                    ex_nop     = 1'b1;
                    if (mem_wait) begin
                        hold_back = 1'b1;
                        if (bus.md_done) begin
                            done_pend_next = 1'b1;
                        end
                    end
                end
            end

            default: state_next = RUN;
        endcase
    end

    assign bus.md_start    = launch & ~rst;
    assign bus.pc_hold     = hold_fetch;
    assign bus.if_id_hold  = hold_fetch;
    assign bus.id_ex_hold  = hold_idex;
    assign bus.ex_mem_hold = hold_back;
    assign bus.mem_wb_hold = hold_back;
    assign bus.if_id_flush = flush;
    assign bus.id_ex_nop   = id_nop;
    assign bus.ex_mem_nop  = ex_nop;
    assign bus.md_err      = md_err_reg;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hold_fetch),
        .clr (bus.cnt_clr),
        .q   (bus.stall_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle MUL/DIV sequences and random stimulus vs a reference model.
module tb_hazard_stall_ctrl;

    localparam int TMO   = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_FLW    = 7'b0000111;
    localparam logic [6:0] C_OP     = 7'b0110011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_BRANCH = 7'b1100011;

    // Output vector bit order: md_start, pc, if_id, id_ex, ex_mem, mem_wb holds, flush, id_ex_nop, ex_mem_nop, md_err
    localparam logic [9:0] E_NONE = 10'b0000000000;
    localparam logic [9:0] E_LU   = 10'b0110000100;
    localparam logic [9:0] E_BR   = 10'b0000001100;
    localparam logic [9:0] E_FRZ  = 10'b0111110000;
    localparam logic [9:0] E_MDL  = 10'b1111000010;
    localparam logic [9:0] E_MDW  = 10'b0111000010;
    localparam logic [9:0] E_XNOP = 10'b0000000010;

    typedef struct packed {
        logic [6:0] opc;
        logic [6:0] f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       im;
        logic       dm;
        logic       done;
        logic       clr;
    } in_t;

    typedef struct {
        in_t        vin;
        logic [9:0] exp;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_stall_ctrl #(
        .MD_TIMEOUT(TMO),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state: is a MUL/DIV outstanding, how long, was its result seen during a freeze.
    bit m_busy, m_pend, m_err;
    int m_wait, m_cnt;

    function automatic in_t mk(input logic [6:0] opc, input logic [6:0] f7, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic br, input logic im, input logic dm,
                               input logic done);
        in_t v;
        v.opc = opc; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.br = br; v.im = im; v.dm = dm; v.done = done; v.clr = 1'b0;
        return v;
    endfunction

    function automatic logic [9:0] model_out(input in_t v);
        logic [9:0] e;
        bit freeze, ld, md, hz;
        freeze = v.im || v.dm;
        ld     = (v.opc == C_LOAD) || (v.opc == C_FLW);
        md     = (v.opc == C_OP) && (v.f7 == 7'h01);
        hz     = ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        e = E_NONE;
        if (!m_busy) begin
            if (freeze)              e = E_FRZ;
            else if (md && !m_err)   e = E_MDL;
            else if (v.br)           e = E_BR;
            else if (hz)             e = E_LU;
        end else begin
            if ((v.done || m_pend) && !freeze) e = E_NONE;
            else if (freeze)                   e = E_FRZ | E_XNOP;
            else if (m_wait == TMO - 1)        e = E_XNOP;
            else                               e = E_MDW;
        end
        e[0] = m_err;
        return e;
    endfunction

    task automatic model_step(input in_t v, input logic [9:0] e);
        bit freeze;
        freeze = v.im || v.dm;
        if (v.clr) m_cnt = 0;
        else if (e[8] && m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (!m_busy) begin
            if (e[9]) begin m_busy = 1; m_wait = 0; m_pend = 0; end
        end else if ((v.done || m_pend) && !freeze) begin
            m_busy = 0; m_pend = 0;
        end else if (m_wait == TMO - 1) begin
            m_busy = 0; m_pend = 0; m_err = 1;
        end else begin
            m_wait = m_wait + 1;
            if (v.done && freeze) m_pend = 1;
        end
    endtask

    task automatic drive(input in_t v);
        bus.ex_opcode       = v.opc;
        bus.ex_funct7       = v.f7;
        bus.ex_rd           = v.rd;
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_use_rs1      = v.u1;
        bus.id_use_rs2      = v.u2;
        bus.ex_branch_taken = v.br;
        bus.im_stall        = v.im;
        bus.dm_stall        = v.dm;
        bus.md_done         = v.done;
        bus.cnt_clr         = v.clr;
    endtask

    function automatic logic [9:0] dut_out();
        return {bus.md_start, bus.pc_hold, bus.if_id_hold, bus.id_ex_hold, bus.ex_mem_hold,
                bus.mem_wb_hold, bus.if_id_flush, bus.id_ex_nop, bus.ex_mem_nop, bus.md_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input in_t v, input string tag);
        logic [9:0] e;
        @(negedge clk);
        drive(v);
        #1;
        e = model_out(v);
        chk({tag, "_outs"}, 32'(dut_out()), 32'(e));
        chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
        $display("%0t %s in=%h outs=%b cnt=%0d", $time, tag, v, dut_out(), bus.stall_cnt);
        model_step(v, e);
    endtask

    task automatic pulse_reset(input in_t v, input string tag);
        logic [9:0] e;
        @(negedge clk);
        drive(v);
        rst = 1'b1;
        #1;
        m_busy = 0; m_pend = 0; m_err = 0; m_cnt = 0; m_wait = 0;
        e = model_out(v);
        e[9] = 1'b0;
        chk({tag, "_outs"}, 32'(dut_out()), 32'(e));
        chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(0));
        chk({tag, "_start"}, 32'(bus.md_start), 32'(0));
        chk({tag, "_err"}, 32'(bus.md_err), 32'(0));
        $display("%0t %s in=%h outs=%b cnt=%0d", $time, tag, v, dut_out(), bus.stall_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    in_t  alu, mul, ld5, clr_v, v;
    row_t tbl[12];

    initial begin
        alu   = mk(C_OP, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mul   = mk(C_OP, 7'h01, 5'd4, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ld5   = mk(C_LOAD, 7'h00, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_v = alu;
        clr_v.clr = 1'b1;
        drive(alu);

        tbl[0]  = '{vin: ld5, exp: E_LU};
        tbl[1]  = '{vin: mk(C_LOAD, 7'h00, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0), exp: E_NONE};
        tbl[2]  = '{vin: mk(C_LOAD, 7'h00, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0), exp: E_NONE};
        tbl[3]  = '{vin: mk(C_LOAD, 7'h00, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0), exp: E_LU};
        tbl[4]  = '{vin: mk(C_FLW, 7'h00, 5'd7, 5'd3, 5'd7, 1, 1, 0, 0, 0, 0), exp: E_LU};
        tbl[5]  = '{vin: mk(C_LOAD, 7'h00, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 0), exp: E_BR};
        tbl[6]  = '{vin: mk(C_OP, 7'h00, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0), exp: E_NONE};
        tbl[7]  = '{vin: mk(C_LOAD, 7'h00, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1, 0), exp: E_FRZ};
        tbl[8]  = '{vin: mk(C_OP, 7'h01, 5'd5, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0), exp: E_FRZ};
        tbl[9]  = '{vin: mk(C_OP, 7'h00, 5'd2, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), exp: E_BR};
        tbl[10] = '{vin: mk(C_STORE, 7'h00, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0), exp: E_NONE};
        tbl[11] = '{vin: mk(C_LOAD, 7'h00, 5'd5, 5'd6, 5'd9, 1, 1, 0, 0, 0, 0), exp: E_NONE};

        // Reset with a MUL in EX: no launch pulse while reset is asserted.
        pulse_reset(mul, "rst0");

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].vin, "tbl");
            chk($sformatf("tbl%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Load-use: one bubble, one stall cycle counted.
        apply(clr_v, "lu_clr");
        apply(ld5, "lu");
        apply(alu, "lu_next");
        chk("lu_cnt", 32'(bus.stall_cnt), 32'(1));
        chk("lu_next_hold", 32'(bus.pc_hold), 32'(0));

        // MUL with result after 4 wait cycles.
        apply(mul, "md_l");
        chk("md_start", 32'(bus.md_start), 32'(1));
        for (int i = 0; i < 4; i++) apply(mul, "md_w");
        v = mul; v.done = 1'b1;
        apply(v, "md_x");
        chk("md_x_hold", 32'(bus.pc_hold), 32'(0));
        chk("md_x_nop", 32'(bus.ex_mem_nop), 32'(0));
        v = alu; v.done = 1'b1;
        apply(v, "md_run");
        chk("md_run_hold", 32'(bus.pc_hold), 32'(0));

        // md_done arrives during a data-memory stall and is remembered.
        apply(mul, "pd_l");
        apply(mul, "pd_w");
        v = mul; v.dm = 1'b1; v.done = 1'b1;
        apply(v, "pd_s");
        chk("pd_s_wb", 32'(bus.mem_wb_hold), 32'(1));
        v.done = 1'b0;
        apply(v, "pd_s");
        apply(v, "pd_s");
        apply(mul, "pd_x");
        chk("pd_x_hold", 32'(bus.pc_hold), 32'(0));
        chk("pd_x_nop", 32'(bus.ex_mem_nop), 32'(0));
        apply(alu, "pd_run");

        // Watchdog: md_done never arrives.
        apply(clr_v, "to_clr");
        apply(mul, "to_l");
        for (int i = 0; i < TMO - 1; i++) apply(mul, "to_w");
        apply(mul, "to_x");
        chk("to_x_hold", 32'(bus.pc_hold), 32'(0));
        chk("to_x_nop", 32'(bus.ex_mem_nop), 32'(1));
        apply(mul, "to_err");
        chk("to_err", 32'(bus.md_err), 32'(1));
        chk("to_nolaunch", 32'(bus.md_start), 32'(0));
        apply(alu, "to_run");
        pulse_reset(alu, "to_rst");

        // Reset in the middle of MD_WAIT.
        apply(mul, "mr_l");
        apply(mul, "mr_w");
        apply(mul, "mr_w");
        pulse_reset(alu, "mr_rst");
        apply(alu, "mr_run");

        // stall_cnt saturation and clear priority.
        apply(clr_v, "sat_clr");
        v = alu; v.im = 1'b1;
        for (int i = 0; i < CMAX + 3; i++) apply(v, "sat");
        chk("sat_max", 32'(bus.stall_cnt), 32'(CMAX));
        v.clr = 1'b1;
        apply(v, "sat_clrhold");
        apply(alu, "sat_after");
        chk("sat_cleared", 32'(bus.stall_cnt), 32'(0));

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            in_t rv;
            case ($urandom_range(0, 5))
                0:       rv.opc = C_LOAD;
                1:       rv.opc = C_FLW;
                2, 3:    rv.opc = C_OP;
                4:       rv.opc = C_STORE;
                default: rv.opc = C_BRANCH;
            endcase
            rv.f7   = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'h00;
            rv.rd   = 5'($urandom_range(0, 7));
            rv.rs1  = 5'($urandom_range(0, 7));
            rv.rs2  = 5'($urandom_range(0, 7));
            rv.u1   = 1'($urandom_range(0, 1));
            rv.u2   = 1'($urandom_range(0, 1));
            rv.br   = ($urandom_range(0, 5) == 0);
            rv.im   = ($urandom_range(0, 9) == 0);
            rv.dm   = ($urandom_range(0, 9) == 0);
            rv.done = ($urandom_range(0, 4) == 0);
            rv.clr  = ($urandom_range(0, 49) == 0);
            if ((i % 400) == 399) pulse_reset(rv, "rrst");
            else apply(rv, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall scheduler for the 5-stage RV32 core. It replaces ad-hoc per-hazard detectors with one controller that sequences all pipeline-register hold, bubble and flush controls. Four sources are prioritised: memory wait, multi-cycle MUL/DIV, branch flush and load-use. It sits beside the ID/EX stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

## Interface
- MD_TIMEOUT, 64: max cycles allowed in MD_WAIT before forced abort
- CNT_W, 32: width of stall performance counter
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_opcode  in  7  opcode of instruction currently in EX
- ex_funct7  in  7  funct7 of instruction in EX
- ex_rd  in  5  destination register of instruction in EX
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- im_stall, dm_stall  in  1 each  instruction / data memory not ready
- md_done  in  1  MUL/DIV unit result valid (level, held until md_start)
- cnt_clr  in  1  synchronous clear of stall_cnt
- md_start  out  1  one-cycle launch pulse to MUL/DIV unit
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold  out  1 each  register freeze
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_nop  out  1  ID/EX loads bubble
- ex_mem_nop  out  1  EX/MEM loads bubble
- md_err  out  1  sticky MUL/DIV timeout flag
- stall_cnt  out  CNT_W  saturating count of cycles with pc_hold=1

## Operation
- Decode:
  - is_load = ex_opcode ∈ {LOAD 7'b0000011, FLW 7'b0000111}.
  - is_md = ex_opcode==7'b0110011 && ex_funct7==7'b0000001.
- mem_wait = im_stall | dm_stall.
- FSM states:
  - RUN → MD_WAIT when is_md && !mem_wait && !md_err_abort; md_start=1 that cycle only.
  - MD_WAIT → RUN on (md_done || done_pend) && !mem_wait, or on timeout.
- RUN priority, highest first:
  1. mem_wait: all five holds = 1; no flush or nop.
  2. is_md launch: pc/if_id/id_ex hold = 1, ex_mem_nop = 1.
  3. ex_branch_taken: if_id_flush = 1, id_ex_nop = 1; load-use suppressed.
  4. Load-use: is_load && ex_rd≠0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)) → pc_hold = if_id_hold = 1, id_ex_nop = 1.
- MD_WAIT:
  - pc/if_id/id_ex hold = 1, ex_mem_nop = 1 until the exit cycle.
  - On the exit cycle holds release and ex_mem_nop = 0, so EX/MEM captures the result.
  - mem_wait in MD_WAIT: all holds = 1. md_done seen during mem_wait sets done_pend, which clears on exit.
- Watchdog:
  - md_cnt clears on entry and increments each MD_WAIT cycle.
  - At md_cnt == MD_TIMEOUT-1: exit to RUN, set md_err (sticky until rst), ex_mem_nop stays 1 (result dropped).
- stall_cnt:
  - Increments when pc_hold=1 and saturates at all-ones.
  - cnt_clr has priority over increment.

## Timing
- Hazard outputs are combinational from current state and inputs (Mealy); state, md_cnt, done_pend, md_err and stall_cnt are registered.
- Load-use costs exactly 1 bubble. The next cycle the load sits in MEM and the hazard term is false.
- Branch flush costs 2 slots (IF/ID, ID/EX) in one cycle.
- MUL/DIV penalty = cycles until md_done plus the launch cycle.
- Reset (asynchronous, immediate) sets:
  - state = RUN, md_cnt = 0, done_pend = 0, md_err = 0, stall_cnt = 0, md_start = 0.
  - Hold/flush/nop outputs follow the RUN equations.
- Reset mid-MD_WAIT returns to RUN with no md_start; the MUL/DIV unit is reset by the same rst.
- Simultaneous branch and load-use: flush wins, no hold.
- Simultaneous mem_wait and any other source: freeze only. The other source is re-evaluated when mem_wait drops because the stage contents are unchanged.

## Structure
- Shared package hazard_pkg holds:
  - state enum {RUN, MD_WAIT}
  - opcode constants LOAD, FLW, OP
  - FUNCT7_MULDIV
- One sub-module: sat_counter (CNT_W, inc, clr, q), used for stall_cnt.
- md_cnt and the FSM stay in the top module.

## Test plan
- ex_opcode=LOAD, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_hold=if_id_hold=id_ex_nop=1 for 1 cycle; stall_cnt=1.
- Same as above but ex_rd=0 or id_use_rs1=0 → no hold, no nop.
- LOAD hazard plus ex_branch_taken=1 in the same cycle → if_id_flush=id_ex_nop=1, pc_hold=0.
- MUL in EX, md_done after 4 cycles → md_start pulse in cycle 0, holds 1 for cycles 0–4, release and ex_mem_nop=0 in the md_done cycle; state back to RUN.
- MD_WAIT with dm_stall=1 while md_done pulses → all holds 1, done_pend=1; exit on the first cycle dm_stall=0.
- md_done never asserted, MD_TIMEOUT=8 → exit after 8 cycles, md_err=1 sticky; assert rst mid-MD_WAIT → state RUN, md_err=0, stall_cnt=0 immediately.
